mem_wb_reg: RTL and testbench
=============================

MEM_WB_REG -- requirements
Module: mem_wb_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning the data path width.
REQ-002 SHALL have parameter PC_W, default 32, meaning the width of the debug PC field.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port stall, input, 1 bit: hold all stage contents.
REQ-006 SHALL have port flush, input, 1 bit: replace the stage contents with a bubble.
REQ-007 SHALL have port mem_valid, input, 1 bit: the upstream slot holds a real instruction.
REQ-008 SHALL have port mem_pc, input, PC_W bits: the instruction PC, carried for debug.
REQ-009 SHALL have ports mem_rfaddr_inchoice (input, 2 bits) and mem_rfaddr1..3 (inputs, 5 bits each): the destination register select and its candidates.
REQ-010 SHALL have ports mem_rfinchoice (input, 3 bits) and mem_rf1..mem_rf6 (inputs, DATA_W bits each): the writeback data select and its candidates.
REQ-011 SHALL have port mem_rf_inallow, input, 1 bit: register-file write enable.
REQ-012 SHALL have ports mem_hi_inchoice, mem_lo_inchoice, mem_hi_we and mem_lo_we, inputs, 1 bit each: HI/LO source selects and HI/LO write enables.
REQ-013 SHALL have ports mem_rs1, mem_rs2, mem_alu_hiout and mem_alu_loout, inputs, DATA_W bits each: the HI/LO data candidates.
REQ-014 SHALL have wb_* outputs, one registered copy of every mem_* field above with identical width, plus wb_valid and wb_pc.
REQ-015 SHALL have port fwd_en, output, 1 bit: a forwardable register write is present in WB.
REQ-016 SHALL have port fwd_addr, output, 5 bits: the resolved destination register held in WB.
REQ-017 SHALL have port retire_cnt, output, 32 bits: the count of retired instructions.

Function
REQ-018 SHALL update state only at the clk rising edge or on rst assertion; latency from mem_* to wb_* SHALL be exactly 1 cycle when neither stall nor flush is asserted.
REQ-019 SHALL apply this priority per edge: rst > flush > stall > load.
REQ-020 On flush, SHALL set wb_valid, wb_rf_inallow, wb_hi_we, wb_lo_we to 0 and all other wb_* fields to 0, regardless of stall.
REQ-021 On stall without flush, SHALL hold every wb_* field and retire_cnt unchanged.
REQ-022 On load with mem_valid=0, SHALL capture the fields but force wb_rf_inallow, wb_hi_we and wb_lo_we to 0 (bubble).
REQ-023 On load with mem_valid=1, SHALL capture all fields unchanged.
REQ-024 SHALL compute fwd_addr combinationally from the registered fields: wb_rfaddr1 when inchoice=00, wb_rfaddr2 when 01, and wb_rfaddr3 otherwise.
REQ-025 SHALL drive fwd_en = wb_valid & wb_rf_inallow & (fwd_addr != 0).
REQ-026 SHALL increment retire_cnt by 1 on each edge that performs a load with mem_valid=1, and wrap from 0xFFFFFFFF to 0.
REQ-027 SHALL NOT increment retire_cnt on flush, stall or bubble edges.

Reset
REQ-028 On rst, SHALL immediately (asynchronously) set every wb_* output, retire_cnt, fwd_en and fwd_addr to 0.
REQ-029 A reset asserted mid-stall SHALL discard the held contents; the first edge after deassertion SHALL perform a normal load.

Structure
REQ-030 SHALL place the rfaddr choice encodings (00/01/other) and the rfinchoice encodings (000, 010, 011, 100, 101) as named constants in the shared pipeline package used by the writeback stage.
REQ-031 SHALL contain no sub-module; the field register bank and the retire counter are inline sequential blocks.

Verification
REQ-032 Load mem_valid=1, mem_rf_inallow=1, rfaddr_inchoice=01, mem_rfaddr2=7, mem_rf1=0x1234 -> next cycle: wb_rf1=0x1234, fwd_addr=7, fwd_en=1, retire_cnt=1.
REQ-033 Assert stall for 3 cycles while mem_* changes -> wb_* and retire_cnt remain constant; the new value appears 1 cycle after stall drops.
REQ-034 Assert stall and flush together -> wb_valid=0, wb_rf_inallow=0, fwd_en=0, retire_cnt unchanged.
REQ-035 Set mem_valid=0 with mem_rf_inallow=1 and mem_hi_we=1 -> wb_rf_inallow=0, wb_hi_we=0, fwd_en=0.
REQ-036 Write to r0 (rfaddr_inchoice=00, mem_rfaddr1=0, valid, allow) -> fwd_en=0, retire_cnt increments.
REQ-037 Preload retire_cnt to 0xFFFFFFFF via force, then issue one valid load -> retire_cnt=0; asserting rst between edges zeroes all outputs without waiting for a clock.

Source files
------------

// File: rtl/mem_wb_reg_pkg.sv
// Shared pipeline constants for the MEM/WB boundary: destination-register and
// writeback-data select encodings, plus the destination resolver used for forwarding.
package mem_wb_reg_pkg;

    localparam int RF_ADDR_W = 5;

    // Destination register select; any code other than these two picks rfaddr3.
    localparam logic [1:0] RFADDR_SEL_1 = 2'b00;
    localparam logic [1:0] RFADDR_SEL_2 = 2'b01;

    // Writeback data select encodings consumed by the writeback stage.
    localparam logic [2:0] RFIN_SEL_1 = 3'b000;
    localparam logic [2:0] RFIN_SEL_2 = 3'b010;
    localparam logic [2:0] RFIN_SEL_3 = 3'b011;
    localparam logic [2:0] RFIN_SEL_4 = 3'b100;
    localparam logic [2:0] RFIN_SEL_5 = 3'b101;

    function automatic logic [RF_ADDR_W-1:0] resolve_rfaddr(
        input logic [1:0]           sel,
        input logic [RF_ADDR_W-1:0] addr1,
        input logic [RF_ADDR_W-1:0] addr2,
        input logic [RF_ADDR_W-1:0] addr3
    );
        logic [RF_ADDR_W-1:0] addr;
        case (sel)
            RFADDR_SEL_1: addr = addr1;
            RFADDR_SEL_2: addr = addr2;
            default:      addr = addr3;
        endcase
        return addr;
    endfunction

    function automatic logic is_rfin_sel_known(input logic [2:0] sel);
        return (sel == RFIN_SEL_1) || (sel == RFIN_SEL_2) || (sel == RFIN_SEL_3) ||
               (sel == RFIN_SEL_4) || (sel == RFIN_SEL_5);
    endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: captures the memory-stage slot each cycle, with flush,
// stall and bubble handling, a forwarding tap and a retired-instruction counter.
module mem_wb_reg
    import mem_wb_reg_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 mem_valid,
    input  logic [PC_W-1:0]      mem_pc,
    input  logic [1:0]           mem_rfaddr_inchoice,
    input  logic [4:0]           mem_rfaddr1,
    input  logic [4:0]           mem_rfaddr2,
    input  logic [4:0]           mem_rfaddr3,
    input  logic [2:0]           mem_rfinchoice,
    input  logic [DATA_W-1:0]    mem_rf1,
    input  logic [DATA_W-1:0]    mem_rf2,
    input  logic [DATA_W-1:0]    mem_rf3,
    input  logic [DATA_W-1:0]    mem_rf4,
    input  logic [DATA_W-1:0]    mem_rf5,
    input  logic [DATA_W-1:0]    mem_rf6,
    input  logic                 mem_rf_inallow,
    input  logic                 mem_hi_inchoice,
    input  logic                 mem_lo_inchoice,
    input  logic                 mem_hi_we,
    input  logic                 mem_lo_we,
    input  logic [DATA_W-1:0]    mem_rs1,
    input  logic [DATA_W-1:0]    mem_rs2,
    input  logic [DATA_W-1:0]    mem_alu_hiout,
    input  logic [DATA_W-1:0]    mem_alu_loout,
    output logic                 wb_valid,
    output logic [PC_W-1:0]      wb_pc,
    output logic [1:0]           wb_rfaddr_inchoice,
    output logic [4:0]           wb_rfaddr1,
    output logic [4:0]           wb_rfaddr2,
    output logic [4:0]           wb_rfaddr3,
    output logic [2:0]           wb_rfinchoice,
    output logic [DATA_W-1:0]    wb_rf1,
    output logic [DATA_W-1:0]    wb_rf2,
    output logic [DATA_W-1:0]    wb_rf3,
    output logic [DATA_W-1:0]    wb_rf4,
    output logic [DATA_W-1:0]    wb_rf5,
    output logic [DATA_W-1:0]    wb_rf6,
    output logic                 wb_rf_inallow,
    output logic                 wb_hi_inchoice,
    output logic                 wb_lo_inchoice,
    output logic                 wb_hi_we,
    output logic                 wb_lo_we,
    output logic [DATA_W-1:0]    wb_rs1,
    output logic [DATA_W-1:0]    wb_rs2,
    output logic [DATA_W-1:0]    wb_alu_hiout,
    output logic [DATA_W-1:0]    wb_alu_loout,
    output logic                 fwd_en,
    output logic [4:0]           fwd_addr,
    output logic [31:0]          retire_cnt
);

    logic load;
    logic retire;

    // Priority is rst > flush > stall > load; a load of an invalid slot is a bubble.
    assign load   = !flush && !stall;
    assign retire = load && mem_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst || flush) begin
            wb_valid           <= 1'b0;
            wb_pc              <= '0;
            wb_rfaddr_inchoice <= '0;
            wb_rfaddr1         <= '0;
            wb_rfaddr2         <= '0;
            wb_rfaddr3         <= '0;
            wb_rfinchoice      <= '0;
            wb_rf1             <= '0;
            wb_rf2             <= '0;
            wb_rf3             <= '0;
            wb_rf4             <= '0;
            wb_rf5             <= '0;
            wb_rf6             <= '0;
            wb_rf_inallow      <= 1'b0;
            wb_hi_inchoice     <= 1'b0;
            wb_lo_inchoice     <= 1'b0;
            wb_hi_we           <= 1'b0;
            wb_lo_we           <= 1'b0;
            wb_rs1             <= '0;
            wb_rs2             <= '0;
            wb_alu_hiout       <= '0;
            wb_alu_loout       <= '0;
        end else if (load) begin
            wb_valid           <= mem_valid;
            wb_pc              <= mem_pc;
            wb_rfaddr_inchoice <= mem_rfaddr_inchoice;
            wb_rfaddr1         <= mem_rfaddr1;
            wb_rfaddr2         <= mem_rfaddr2;
            wb_rfaddr3         <= mem_rfaddr3;
            wb_rfinchoice      <= mem_rfinchoice;
            wb_rf1             <= mem_rf1;
            wb_rf2             <= mem_rf2;
            wb_rf3             <= mem_rf3;
            wb_rf4             <= mem_rf4;
            wb_rf5             <= mem_rf5;
            wb_rf6             <= mem_rf6;
            wb_rf_inallow      <= mem_rf_inallow && mem_valid;
            wb_hi_inchoice     <= mem_hi_inchoice;
            wb_lo_inchoice     <= mem_lo_inchoice;
            wb_hi_we           <= mem_hi_we && mem_valid;
            wb_lo_we           <= mem_lo_we && mem_valid;
            wb_rs1             <= mem_rs1;
            wb_rs2             <= mem_rs2;
            wb_alu_hiout       <= mem_alu_hiout;
            wb_alu_loout       <= mem_alu_loout;
        end
    end

    // Free-running wrap from all-ones back to zero is intended.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retire_cnt <= '0;
        end else if (retire) begin
            retire_cnt <= retire_cnt + 32'd1;
        end
    end

    // Writes to r0 are architecturally discarded, so they are never forwarded.
    assign fwd_addr = resolve_rfaddr(wb_rfaddr_inchoice, wb_rfaddr1, wb_rfaddr2, wb_rfaddr3);
    assign fwd_en   = wb_valid && wb_rf_inallow && (fwd_addr != 5'd0);

endmodule

// File: tb/tb_mem_wb_reg.sv
// Directed-vector bench for mem_wb_reg: one task per scenario, inline comparisons
// against hand-computed values, single summary line at the end.
module tb_mem_wb_reg;

    localparam int DATA_W = 32;
    localparam int PC_W   = 32;

    logic              clk = 1'b0;
    logic              rst, stall, flush, mem_valid;
    logic [PC_W-1:0]   mem_pc;
    logic [1:0]        mem_rfaddr_inchoice;
    logic [4:0]        mem_rfaddr1, mem_rfaddr2, mem_rfaddr3;
    logic [2:0]        mem_rfinchoice;
    logic [DATA_W-1:0] mem_rf1, mem_rf2, mem_rf3, mem_rf4, mem_rf5, mem_rf6;
    logic              mem_rf_inallow, mem_hi_inchoice, mem_lo_inchoice, mem_hi_we, mem_lo_we;
    logic [DATA_W-1:0] mem_rs1, mem_rs2, mem_alu_hiout, mem_alu_loout;

    logic              wb_valid;
    logic [PC_W-1:0]   wb_pc;
    logic [1:0]        wb_rfaddr_inchoice;
    logic [4:0]        wb_rfaddr1, wb_rfaddr2, wb_rfaddr3;
    logic [2:0]        wb_rfinchoice;
    logic [DATA_W-1:0] wb_rf1, wb_rf2, wb_rf3, wb_rf4, wb_rf5, wb_rf6;
    logic              wb_rf_inallow, wb_hi_inchoice, wb_lo_inchoice, wb_hi_we, wb_lo_we;
    logic [DATA_W-1:0] wb_rs1, wb_rs2, wb_alu_hiout, wb_alu_loout;
    logic              fwd_en;
    logic [4:0]        fwd_addr;
    logic [31:0]       retire_cnt;

    int n_cmp = 0;
    int n_err = 0;

    mem_wb_reg #(.DATA_W(DATA_W), .PC_W(PC_W)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .mem_valid(mem_valid), .mem_pc(mem_pc),
        .mem_rfaddr_inchoice(mem_rfaddr_inchoice),
        .mem_rfaddr1(mem_rfaddr1), .mem_rfaddr2(mem_rfaddr2), .mem_rfaddr3(mem_rfaddr3),
        .mem_rfinchoice(mem_rfinchoice),
        .mem_rf1(mem_rf1), .mem_rf2(mem_rf2), .mem_rf3(mem_rf3),
        .mem_rf4(mem_rf4), .mem_rf5(mem_rf5), .mem_rf6(mem_rf6),
        .mem_rf_inallow(mem_rf_inallow),
        .mem_hi_inchoice(mem_hi_inchoice), .mem_lo_inchoice(mem_lo_inchoice),
        .mem_hi_we(mem_hi_we), .mem_lo_we(mem_lo_we),
        .mem_rs1(mem_rs1), .mem_rs2(mem_rs2),
        .mem_alu_hiout(mem_alu_hiout), .mem_alu_loout(mem_alu_loout),
        .wb_valid(wb_valid), .wb_pc(wb_pc),
        .wb_rfaddr_inchoice(wb_rfaddr_inchoice),
        .wb_rfaddr1(wb_rfaddr1), .wb_rfaddr2(wb_rfaddr2), .wb_rfaddr3(wb_rfaddr3),
        .wb_rfinchoice(wb_rfinchoice),
        .wb_rf1(wb_rf1), .wb_rf2(wb_rf2), .wb_rf3(wb_rf3),
        .wb_rf4(wb_rf4), .wb_rf5(wb_rf5), .wb_rf6(wb_rf6),
        .wb_rf_inallow(wb_rf_inallow),
        .wb_hi_inchoice(wb_hi_inchoice), .wb_lo_inchoice(wb_lo_inchoice),
        .wb_hi_we(wb_hi_we), .wb_lo_we(wb_lo_we),
        .wb_rs1(wb_rs1), .wb_rs2(wb_rs2),
        .wb_alu_hiout(wb_alu_hiout), .wb_alu_loout(wb_alu_loout),
        .fwd_en(fwd_en), .fwd_addr(fwd_addr), .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        stall = 0; flush = 0; mem_valid = 0; mem_pc = '0;
        mem_rfaddr_inchoice = 2'b00; mem_rfaddr1 = 0; mem_rfaddr2 = 0; mem_rfaddr3 = 0;
        mem_rfinchoice = 3'b000;
        mem_rf1 = 0; mem_rf2 = 0; mem_rf3 = 0; mem_rf4 = 0; mem_rf5 = 0; mem_rf6 = 0;
        mem_rf_inallow = 0; mem_hi_inchoice = 0; mem_lo_inchoice = 0;
        mem_hi_we = 0; mem_lo_we = 0;
        mem_rs1 = 0; mem_rs2 = 0; mem_alu_hiout = 0; mem_alu_loout = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        drive_idle();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %0b expected 0", wb_valid); end
        n_cmp++; if (wb_pc !== 32'h0) begin n_err++; $display("FAIL reset_pc: got %h expected 0", wb_pc); end
        n_cmp++; if (fwd_en !== 1'b0) begin n_err++; $display("FAIL reset_fwd_en: got %0b expected 0", fwd_en); end
        n_cmp++; if (retire_cnt !== 32'h0) begin n_err++; $display("FAIL reset_retire: got %h expected 0", retire_cnt); end
        rst = 0;
    endtask

    task automatic test_load();
        mem_valid = 1; mem_pc = 32'h0000_0100;
        mem_rfaddr_inchoice = 2'b01; mem_rfaddr1 = 5'd3; mem_rfaddr2 = 5'd7; mem_rfaddr3 = 5'd9;
        mem_rfinchoice = 3'b010;
        mem_rf1 = 32'h1234; mem_rf2 = 32'h22; mem_rf3 = 32'h33; mem_rf4 = 32'h44;
        mem_rf5 = 32'h55; mem_rf6 = 32'h66;
        mem_rf_inallow = 1; mem_hi_inchoice = 1; mem_lo_inchoice = 0;
        mem_hi_we = 1; mem_lo_we = 0;
        mem_rs1 = 32'hA1; mem_rs2 = 32'hA2; mem_alu_hiout = 32'hB1; mem_alu_loout = 32'hB2;
        step();
        n_cmp++; if (wb_rf1 !== 32'h1234) begin n_err++; $display("FAIL load_rf1: got %h expected 1234", wb_rf1); end
        n_cmp++; if (fwd_addr !== 5'd7) begin n_err++; $display("FAIL load_fwd_addr: got %0d expected 7", fwd_addr); end
        n_cmp++; if (fwd_en !== 1'b1) begin n_err++; $display("FAIL load_fwd_en: got %0b expected 1", fwd_en); end
        n_cmp++; if (retire_cnt !== 32'd1) begin n_err++; $display("FAIL load_retire: got %0d expected 1", retire_cnt); end
        n_cmp++; if (wb_pc !== 32'h100) begin n_err++; $display("FAIL load_pc: got %h expected 100", wb_pc); end
        n_cmp++; if (wb_rfinchoice !== 3'b010) begin n_err++; $display("FAIL load_rfinchoice: got %b expected 010", wb_rfinchoice); end
        n_cmp++; if (wb_rf6 !== 32'h66) begin n_err++; $display("FAIL load_rf6: got %h expected 66", wb_rf6); end
        n_cmp++; if (wb_hi_we !== 1'b1 || wb_lo_we !== 1'b0) begin n_err++; $display("FAIL load_hilo_we: got %0b%0b expected 10", wb_hi_we, wb_lo_we); end
        n_cmp++; if (wb_alu_hiout !== 32'hB1 || wb_rs2 !== 32'hA2) begin n_err++; $display("FAIL load_hilo_data: got %h/%h expected b1/a2", wb_alu_hiout, wb_rs2); end
    endtask

    task automatic test_addr_select();
        mem_rfaddr_inchoice = 2'b00;
        step();
        n_cmp++; if (fwd_addr !== 5'd3) begin n_err++; $display("FAIL sel00_addr: got %0d expected 3", fwd_addr); end
        mem_rfaddr_inchoice = 2'b10;
        step();
        n_cmp++; if (fwd_addr !== 5'd9) begin n_err++; $display("FAIL sel10_addr: got %0d expected 9", fwd_addr); end
        mem_rfaddr_inchoice = 2'b11; mem_rf1 = 32'h5555;
        step();
        n_cmp++; if (fwd_addr !== 5'd9) begin n_err++; $display("FAIL sel11_addr: got %0d expected 9", fwd_addr); end
        n_cmp++; if (retire_cnt !== 32'd4) begin n_err++; $display("FAIL sel_retire: got %0d expected 4", retire_cnt); end
    endtask

    task automatic test_stall();
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            mem_rf1 = 32'hAAA0 + i;
            mem_pc  = 32'h200 + i;
            step();
            n_cmp++; if (wb_rf1 !== 32'h5555) begin n_err++; $display("FAIL stall_hold_rf1: got %h expected 5555", wb_rf1); end
            n_cmp++; if (retire_cnt !== 32'd4) begin n_err++; $display("FAIL stall_hold_retire: got %0d expected 4", retire_cnt); end
        end
        stall = 0;
        step();
        n_cmp++; if (wb_rf1 !== 32'hAAA2) begin n_err++; $display("FAIL stall_release_rf1: got %h expected aaa2", wb_rf1); end
        n_cmp++; if (wb_pc !== 32'h202) begin n_err++; $display("FAIL stall_release_pc: got %h expected 202", wb_pc); end
        n_cmp++; if (retire_cnt !== 32'd5) begin n_err++; $display("FAIL stall_release_retire: got %0d expected 5", retire_cnt); end
    endtask

    task automatic test_stall_flush();
        stall = 1; flush = 1;
        step();
        n_cmp++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid: got %0b expected 0", wb_valid); end
        n_cmp++; if (wb_rf_inallow !== 1'b0) begin n_err++; $display("FAIL flush_inallow: got %0b expected 0", wb_rf_inallow); end
        n_cmp++; if (fwd_en !== 1'b0) begin n_err++; $display("FAIL flush_fwd_en: got %0b expected 0", fwd_en); end
        n_cmp++; if (wb_rf1 !== 32'h0 || wb_pc !== 32'h0) begin n_err++; $display("FAIL flush_fields: got %h/%h expected 0/0", wb_rf1, wb_pc); end
        n_cmp++; if (retire_cnt !== 32'd5) begin n_err++; $display("FAIL flush_retire: got %0d expected 5", retire_cnt); end
        stall = 0; flush = 0;
    endtask

    task automatic test_bubble();
        mem_valid = 0; mem_rf_inallow = 1; mem_hi_we = 1; mem_lo_we = 1;
        mem_rfaddr_inchoice = 2'b01; mem_rf1 = 32'hBEEF;
        step();
        n_cmp++; if (wb_rf_inallow !== 1'b0) begin n_err++; $display("FAIL bubble_inallow: got %0b expected 0", wb_rf_inallow); end
        n_cmp++; if (wb_hi_we !== 1'b0 || wb_lo_we !== 1'b0) begin n_err++; $display("FAIL bubble_hilo_we: got %0b%0b expected 00", wb_hi_we, wb_lo_we); end
        n_cmp++; if (fwd_en !== 1'b0) begin n_err++; $display("FAIL bubble_fwd_en: got %0b expected 0", fwd_en); end
        n_cmp++; if (wb_rf1 !== 32'hBEEF) begin n_err++; $display("FAIL bubble_capture: got %h expected beef", wb_rf1); end
        n_cmp++; if (retire_cnt !== 32'd5) begin n_err++; $display("FAIL bubble_retire: got %0d expected 5", retire_cnt); end
    endtask

    task automatic test_r0_write();
        mem_valid = 1; mem_rf_inallow = 1; mem_hi_we = 0; mem_lo_we = 0;
        mem_rfaddr_inchoice = 2'b00; mem_rfaddr1 = 5'd0;
        step();
        n_cmp++; if (fwd_en !== 1'b0) begin n_err++; $display("FAIL r0_fwd_en: got %0b expected 0", fwd_en); end
        n_cmp++; if (wb_rf_inallow !== 1'b1) begin n_err++; $display("FAIL r0_inallow: got %0b expected 1", wb_rf_inallow); end
        n_cmp++; if (retire_cnt !== 32'd6) begin n_err++; $display("FAIL r0_retire: got %0d expected 6", retire_cnt); end
    endtask

    task automatic test_wrap_and_async_reset();
        force dut.retire_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.retire_cnt;
        mem_valid = 1; mem_rf_inallow = 1; mem_rfaddr_inchoice = 2'b01; mem_rfaddr2 = 5'd7;
        mem_rf1 = 32'hCAFE; mem_pc = 32'h300;
        step();
        n_cmp++; if (retire_cnt !== 32'h0) begin n_err++; $display("FAIL wrap_retire: got %h expected 0", retire_cnt); end
        n_cmp++; if (fwd_en !== 1'b1) begin n_err++; $display("FAIL wrap_fwd_en: got %0b expected 1", fwd_en); end
        mem_valid = 1;
        step();
        #2;
        rst = 1;
        #1;
        n_cmp++; if (wb_valid !== 1'b0 || wb_rf1 !== 32'h0 || wb_pc !== 32'h0) begin n_err++; $display("FAIL async_rst_fields: got %0b/%h/%h expected 0/0/0", wb_valid, wb_rf1, wb_pc); end
        n_cmp++; if (fwd_addr !== 5'd0 || fwd_en !== 1'b0) begin n_err++; $display("FAIL async_rst_fwd: got %0d/%0b expected 0/0", fwd_addr, fwd_en); end
        n_cmp++; if (retire_cnt !== 32'h0) begin n_err++; $display("FAIL async_rst_retire: got %h expected 0", retire_cnt); end
        rst = 0;
    endtask

    task automatic test_reset_mid_stall();
        mem_valid = 1; mem_rf1 = 32'h1111; mem_pc = 32'h400;
        step();
        stall = 1; mem_rf1 = 32'h2222; mem_pc = 32'h404;
        step();
        n_cmp++; if (wb_rf1 !== 32'h1111) begin n_err++; $display("FAIL midstall_hold: got %h expected 1111", wb_rf1); end
        rst = 1;
        #1;
        n_cmp++; if (wb_rf1 !== 32'h0 || retire_cnt !== 32'h0) begin n_err++; $display("FAIL midstall_rst: got %h/%h expected 0/0", wb_rf1, retire_cnt); end
        rst = 0; stall = 0;
        step();
        n_cmp++; if (wb_rf1 !== 32'h2222 || wb_pc !== 32'h404) begin n_err++; $display("FAIL post_rst_load: got %h/%h expected 2222/404", wb_rf1, wb_pc); end
        n_cmp++; if (retire_cnt !== 32'd1) begin n_err++; $display("FAIL post_rst_retire: got %0d expected 1", retire_cnt); end
    endtask

    task automatic test_flush_only();
        flush = 1;
        step();
        n_cmp++; if (wb_valid !== 1'b0 || wb_rf1 !== 32'h0) begin n_err++; $display("FAIL flush_only: got %0b/%h expected 0/0", wb_valid, wb_rf1); end
        n_cmp++; if (retire_cnt !== 32'd1) begin n_err++; $display("FAIL flush_only_retire: got %0d expected 1", retire_cnt); end
        flush = 0;
    endtask

    initial begin
        test_reset();
        test_load();
        test_addr_select();
        test_stall();
        test_stall_flush();
        test_bubble();
        test_r0_write();
        test_wrap_and_async_reset();
        test_reset_mid_stall();
        test_flush_only();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
